key_conditioner: RTL and testbench



---
 rtl/key_cond_pkg.sv | 36 +++
 rtl/key_channel.sv | 142 ++++++++++++++
 rtl/key_conditioner.sv | 51 +++++
 tb/tb_key_conditioner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// key_cond_pkg
// Shared definitions for the push-button conditioner: per-key FSM state
// encoding, default timing constants (50 MHz system clock) and the counter
// width helper used by key_channel.
package key_cond_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    REL_DB
  } key_state_e;

  localparam int unsigned DEF_N_BTN           = 3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_CYCLES   = 5_000_000;   // 100 ms

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One counter serves all three timers; it only ever counts up to
  // (limit-1) from a cleared value, so $clog2(limit) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned db,
                                            input int unsigned hold,
                                            input int unsigned rep);
    return $clog2(max3(db, hold, rep));
  endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel
// Conditions one active-low raw key: two-flop synchroniser, debounce/hold
// FSM with a single shared counter, and registered output pulses.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   key_n_i    raw key, asynchronous, 0 = pressed
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse when a press is accepted
//   release_o  one-cycle pulse when a release is accepted
//   repeat_o   one-cycle auto-repeat pulse during a long hold
module key_channel
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          p;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // Synchroniser resets to "released" so a held key after reset is seen
  // as a fresh press with full latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

  assign p = ~sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // Input-change checks take priority over timer expiry, so a key that
  // drops on the very cycle the timer expires is treated as a glitch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (p) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (!p) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d  = REPEAT;
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
      end
      REPEAT: begin
        if (!p) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
      end
      REL_DB: begin
        // A bounce back to pressed restarts the hold timer from zero.
        if (p) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level is registered alongside the pulses so press and level rise together.
    level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == REL_DB);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
// Conditions the board's raw active-low push-buttons for the display
// controller. One independent key_channel per key; btn_event merges the
// press and auto-repeat pulses for the controller's buttons input.
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   key_n          raw keys, 0 = pressed
//   btn_level      debounced level, 1 = pressed
//   btn_press      one-cycle press pulses
//   btn_release    one-cycle release pulses
//   btn_repeat     one-cycle auto-repeat pulses
//   btn_event      btn_press | btn_repeat
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned N_BTN           = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] key_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_event
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_channel (
      .clk_i     (clk_clk),
      .rst_ni    (reset_reset_n),
      .key_n_i   (key_n[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g]),
      .repeat_o  (btn_repeat[g])
    );
  end

  // Both terms are registered, so the event output is glitch-free.
  assign btn_event = btn_press | btn_repeat;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int unsigned NB   = 3;
  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 8;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [NB-1:0] key_n;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat, btn_event;

  key_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .key_n         (key_n),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .btn_repeat    (btn_repeat),
    .btn_event     (btn_event)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each key's debounced level flips after DB+1
  // consecutive synchronised samples disagreeing with it; auto-repeat is a
  // timestamp schedule (HOLD after press or after a bounce back, then REP).
  logic [NB-1:0] m_s1, m_s2;
  int            m_run  [NB];
  bit            m_lvl  [NB];
  int            m_next [NB];
  int            m_cyc;
  logic [NB-1:0] exp_lvl, exp_press, exp_rel, exp_rep;

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1;
    m_s2 = '1;
    m_cyc = 0;
    for (int i = 0; i < NB; i++) begin
      m_run[i]  = 0;
      m_lvl[i]  = 1'b0;
      m_next[i] = 0;
    end
    exp_lvl   = '0;
    exp_press = '0;
    exp_rel   = '0;
    exp_rep   = '0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] p;
    if (!reset_reset_n) begin
      model_reset();
      return;
    end
    p     = ~m_s2;
    m_s2  = m_s1;
    m_s1  = key_n;
    m_cyc = m_cyc + 1;
    exp_press = '0;
    exp_rel   = '0;
    exp_rep   = '0;
    for (int i = 0; i < NB; i++) begin
      if (!m_lvl[i]) begin
        if (p[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_lvl[i]     = 1'b1;
            exp_press[i] = 1'b1;
            m_run[i]     = 0;
            m_next[i]    = m_cyc + HOLD;
          end
        end else begin
          m_run[i] = 0;
        end
      end else begin
        if (!p[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_lvl[i]   = 1'b0;
            exp_rel[i] = 1'b1;
            m_run[i]   = 0;
          end
        end else if (m_run[i] > 0) begin
          m_run[i]  = 0;
          m_next[i] = m_cyc + HOLD;
        end else if (m_cyc == m_next[i]) begin
          exp_rep[i] = 1'b1;
          m_next[i]  = m_cyc + REP;
        end
      end
      exp_lvl[i] = m_lvl[i];
    end
  endtask

  task automatic check_all();
    check("level",   btn_level,   exp_lvl);
    check("press",   btn_press,   exp_press);
    check("release", btn_release, exp_rel);
    check("repeat",  btn_repeat,  exp_rep);
    check("event",   btn_event,   exp_press | exp_rep);
  endtask

  task automatic step(input logic [NB-1:0] k);
    key_n = k;
    @(posedge clk_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('1);
  endtask

  initial begin
    logic [NB-1:0] k;
    int            len [NB];

    reset_reset_n = 1'b0;
    key_n         = '1;
    model_reset();
    #2;
    check_all();
    step('1);
    step('1);
    #2 reset_reset_n = 1'b1;
    idle(5);

    // Clean press on key 0: low for 10 cycles.
    for (int t = 0; t < 20; t++) begin
      step((t < 10) ? 3'b110 : 3'b111);
      check("cp_press", btn_press & 3'b001, (t == 6) ? 3'b001 : 3'b000);
      check("cp_level", btn_level & 3'b001, (t >= 6 && t < 16) ? 3'b001 : 3'b000);
      check("cp_rel",   btn_release & 3'b001, (t == 16) ? 3'b001 : 3'b000);
    end
    idle(4);

    // Glitch on key 1: low for 3 cycles only.
    for (int t = 0; t < 12; t++) begin
      step((t < 3) ? 3'b101 : 3'b111);
      check("gl_quiet", (btn_level | btn_press | btn_release | btn_repeat | btn_event) & 3'b010, 3'b000);
    end
    idle(4);

    // Release bounce on key 0: final rise sampled at t=13.
    for (int t = 0; t < 25; t++) begin
      step((t < 10 || t == 12) ? 3'b110 : 3'b111);
      check("rb_press", btn_press & 3'b001, (t == 6) ? 3'b001 : 3'b000);
      check("rb_level", btn_level & 3'b001, (t >= 6 && t < 19) ? 3'b001 : 3'b000);
      check("rb_rel",   btn_release & 3'b001, (t == 19) ? 3'b001 : 3'b000);
    end
    idle(4);

    // Long hold on key 2: 60 cycles.
    for (int t = 0; t < 70; t++) begin
      logic r;
      step((t < 60) ? 3'b011 : 3'b111);
      r = (t == 26 || t == 34 || t == 42 || t == 50 || t == 58);
      check("lh_press",  btn_press & 3'b100,  (t == 6) ? 3'b100 : 3'b000);
      check("lh_repeat", btn_repeat & 3'b100, r ? 3'b100 : 3'b000);
      check("lh_event",  btn_event & 3'b100,  (r || t == 6) ? 3'b100 : 3'b000);
      check("lh_rel",    btn_release & 3'b100, (t == 66) ? 3'b100 : 3'b000);
    end
    idle(4);

    // Simultaneous press on all keys.
    for (int t = 0; t < 16; t++) begin
      step((t < 8) ? 3'b000 : 3'b111);
      check("sim_press", btn_press,   (t == 6)  ? 3'b111 : 3'b000);
      check("sim_rel",   btn_release, (t == 14) ? 3'b111 : 3'b000);
    end
    idle(4);

    // Reset while key 0 is auto-repeating.
    for (int t = 0; t <= 30; t++) step(3'b110);
    check("rst_pre_level", btn_level & 3'b001, 3'b001);
    #2 reset_reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_async", btn_level | btn_press | btn_release | btn_repeat | btn_event, 3'b000);
    step(3'b110);
    step(3'b110);
    #2 reset_reset_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      step((t < 10) ? 3'b110 : 3'b111);
      check("rst_press", btn_press & 3'b001,   (t == 6)  ? 3'b001 : 3'b000);
      check("rst_rel",   btn_release & 3'b001, (t == 16) ? 3'b001 : 3'b000);
    end
    idle(4);

    // Randomised per-key run lengths, with one mid-run reset.
    k = '1;
    for (int i = 0; i < NB; i++) len[i] = $urandom_range(1, 30);
    for (int s = 0; s < 1500; s++) begin
      for (int i = 0; i < NB; i++) begin
        if (len[i] == 0) begin
          k[i]   = ~k[i];
          len[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(35, 70) : $urandom_range(1, 12);
        end
        len[i]--;
      end
      if (s == 700) begin
        #2 reset_reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step(k);
        #2 reset_reset_n = 1'b1;
      end
      step(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
